// File: rtl/seven_seg_pkg.sv
// Shared types and segment codes for the seven-segment display blocks.
// Segment codes are active-low: bit7 = DP, bits6:0 = g..a.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int         DP_BIT  = 7;

endpackage

// File: rtl/seg_bcd_decode.sv
// Combinational BCD nibble to active-low segment code.
// Non-decimal nibbles and blanked digits go dark; a lit DP survives blanking.
module seg_bcd_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] code
);

    always_comb begin
        code = SEG_OFF;
        if (!blank) begin
            case (nibble)
                4'd0:    code = SEG_0;
                4'd1:    code = SEG_1;
                4'd2:    code = SEG_2;
                4'd3:    code = SEG_3;
                4'd4:    code = SEG_4;
                4'd5:    code = SEG_5;
                4'd6:    code = SEG_6;
                4'd7:    code = SEG_7;
                4'd8:    code = SEG_8;
                4'd9:    code = SEG_9;
                default: code = SEG_OFF;
            endcase
        end
        if (dp) begin
            code[DP_BIT] = 1'b0;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for common-anode digits on a shared segment bus.
// Outputs are registered from next-state values so they line up with the state they describe.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [7:0]              segment,
    output logic [NUM_DIGITS-1:0]   digit_an,
    output logic                    frame_done
);

    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LOAD  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    scan_state_e state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [IW-1:0] idx, idx_nx;

    logic [4*NUM_DIGITS-1:0] active_bcd, active_bcd_nx, pend_bcd;
    logic [NUM_DIGITS-1:0]   active_dp, active_dp_nx, pend_dp;
    logic                    pend_valid, pend_valid_nx;
    logic                    accept, transfer;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic [3:0]            nib;
    logic                  nib_dp, nib_blank;
    logic [7:0]            dec_code;

    logic [7:0]            seg_nx;
    logic [NUM_DIGITS-1:0] an_nx;
    logic                  fd_nx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state logic; the slot counter reloads on every state change
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = BLANK;
                    cnt_nx   = BLANK_LOAD;
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state_nx = SHOW;
                        cnt_nx   = SHOW_LOAD;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt == '0) begin
                        state_nx = BLANK;
                        cnt_nx   = BLANK_LOAD;
                        idx_nx   = (idx == LAST_IDX) ? '0 : idx + IW'(1);
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    // frame_done is high exactly during the last SHOW cycle of the last digit,
    // so a pending value swaps in at the edge that closes the frame.
    assign accept   = load_valid && load_ready;
    assign transfer = pend_valid && (frame_done || state == IDLE);

    always_comb begin
        active_bcd_nx = transfer ? pend_bcd : active_bcd;
        active_dp_nx  = transfer ? pend_dp  : active_dp;
        pend_valid_nx = pend_valid;
        if (transfer) begin
            pend_valid_nx = 1'b0;
        end else if (accept) begin
            pend_valid_nx = 1'b1;
        end
    end

    // Leading zeros: a digit is blanked when it and every digit above it are zero
    always_comb begin
        logic run;
        run     = blank_lz;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run        = run && (active_bcd_nx[4*i +: 4] == 4'd0);
            lz_mask[i] = run;
        end
    end

    always_comb begin
        nib       = '0;
        nib_dp    = 1'b0;
        nib_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nx == IW'(i)) begin
                nib       = active_bcd_nx[4*i +: 4];
                nib_dp    = active_dp_nx[i];
                nib_blank = lz_mask[i];
            end
        end
    end

    seg_bcd_decode u_decode (
        .nibble (nib),
        .dp     (nib_dp),
        .blank  (nib_blank),
        .code   (dec_code)
    );

    // Output logic: derived from the state the next cycle will hold
    always_comb begin
        seg_nx = SEG_OFF;
        an_nx  = '1;
        fd_nx  = 1'b0;
        if (state_nx == SHOW) begin
            seg_nx = dec_code;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_nx == IW'(i)) begin
                    an_nx[i] = 1'b0;
                end
            end
            fd_nx = (cnt_nx == '0) && (idx_nx == LAST_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_bcd <= '0;
            active_dp  <= '0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            load_ready <= 1'b1;
            segment    <= SEG_OFF;
            digit_an   <= '1;
            frame_done <= 1'b0;
        end else begin
            active_bcd <= active_bcd_nx;
            active_dp  <= active_dp_nx;
            if (accept) begin
                pend_bcd <= bcd_in;
                pend_dp  <= dp_in;
            end
            pend_valid <= pend_valid_nx;
            load_ready <= !pend_valid_nx;
            segment    <= seg_nx;
            digit_an   <= an_nx;
            frame_done <= fd_nx;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: 4 digits, 8-cycle slots, 2-cycle blanking gaps.
// Frame vectors from a table, plus hand sequences for mid-frame load, enable drop and reset.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int PS    = 8;
    localparam int BL    = 2;
    localparam int SLOT  = PS + BL;
    localparam int FRAME = ND * SLOT;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic            blank_lz;
    logic            load_valid;
    logic            load_ready;
    logic [4*ND-1:0] bcd_in;
    logic [ND-1:0]   dp_in;
    logic [7:0]      segment;
    logic [ND-1:0]   digit_an;
    logic            frame_done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        lz;
        logic [31:0] segs;   // expected codes {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [10];

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .segment    (segment),
        .digit_an   (digit_an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected outputs at cycle k of a frame that starts with a blanking gap
    task automatic check_frame_cycle(input string tag, input int k, input logic [31:0] segs);
        int d;
        int c;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        d = k / SLOT;
        c = k % SLOT;
        if (c < BL) begin
            e_an  = 4'b1111;
            e_seg = 8'hFF;
        end else begin
            e_an  = ~(4'b0001 << d);
            e_seg = segs[8*d +: 8];
        end
        check({tag, "_an"}, 32'(digit_an), 32'(e_an));
        check({tag, "_seg"}, 32'(segment), 32'(e_seg));
        check({tag, "_fd"}, 32'(frame_done), 32'(k == FRAME - 1));
    endtask

    task automatic check_frame(input string tag, input logic [31:0] segs);
        for (int k = 0; k < FRAME; k++) begin
            tick();
            check_frame_cycle(tag, k, segs);
        end
    endtask

    // Offer a value while the scanner is idle; it becomes active one clock after acceptance
    task automatic load_idle(input logic [15:0] v, input logic [3:0] d);
        int w;
        enable = 1'b0;
        tick();
        w = 0;
        while (!load_ready && w < 20) begin
            tick();
            w++;
        end
        check("ready_wait_timeout", 32'(w < 20), 32'd1);
        bcd_in     = v;
        dp_in      = d;
        load_valid = 1'b1;
        tick();
        check("ready_drop", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        tick();
        check("ready_rise", 32'(load_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 32'hF9A4B099};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, 32'hFFFF92C0};
        vecs[2] = '{16'h0050, 4'b0000, 1'b0, 32'hC0C092C0};
        vecs[3] = '{16'h8A00, 4'b1000, 1'b0, 32'h00FFC0C0};
        vecs[4] = '{16'h0007, 4'b0100, 1'b1, 32'hFF7FFFF8};
        vecs[5] = '{16'h5678, 4'b0001, 1'b1, 32'h9282F800};
        vecs[6] = '{16'h9000, 4'b0000, 1'b1, 32'h90C0C0C0};
        vecs[7] = '{16'h0000, 4'b0000, 1'b1, 32'hFFFFFFC0};
        vecs[8] = '{16'h00F0, 4'b0000, 1'b0, 32'hC0C0FFC0};
        vecs[9] = '{16'h0F00, 4'b1001, 1'b1, 32'h7FFFC040};

        rst_n      = 1'b0;
        enable     = 1'b0;
        blank_lz   = 1'b0;
        load_valid = 1'b0;
        bcd_in     = '0;
        dp_in      = '0;
        repeat (3) tick();
        check("rst_seg", 32'(segment), 32'hFF);
        check("rst_an", 32'(digit_an), 32'hF);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd1);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_seg", 32'(segment), 32'hFF);
        check("idle_an", 32'(digit_an), 32'hF);

        // Table-driven frames, each loaded from idle
        for (int v = 0; v < 10; v++) begin
            blank_lz = vecs[v].lz;
            load_idle(vecs[v].bcd, vecs[v].dp);
            enable = 1'b1;
            check_frame($sformatf("vec%0d", v), vecs[v].segs);
        end

        // Mid-frame load: held second offer stalls, swap only at the frame boundary
        blank_lz = 1'b0;
        load_idle(16'h1234, 4'b0000);
        enable = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            check_frame_cycle("midload_old", k, 32'hF9A4B099);
            if (k >= 16) check("midload_ready_low", 32'(load_ready), 32'd0);
            if (k == 15) begin
                bcd_in     = 16'h1111;
                dp_in      = 4'b0000;
                load_valid = 1'b1;
            end
            if (k == 16) bcd_in = 16'h2222;
            if (k == 20) load_valid = 1'b0;
        end
        for (int k = 0; k < FRAME; k++) begin
            tick();
            check_frame_cycle("midload_new", k, 32'hF9F9F9F9);
            if (k == 0) check("midload_ready_back", 32'(load_ready), 32'd1);
        end

        // Enable drop during SHOW of digit 0, then restart from the blanking gap
        for (int k = 0; k < 5; k++) begin
            tick();
            check_frame_cycle("endrop_pre", k, 32'hF9F9F9F9);
        end
        enable = 1'b0;
        tick();
        check("endrop_an", 32'(digit_an), 32'hF);
        check("endrop_seg", 32'(segment), 32'hFF);
        check("endrop_fd", 32'(frame_done), 32'd0);
        tick();
        check("endrop_idle_an", 32'(digit_an), 32'hF);
        enable = 1'b1;
        check_frame("reenable", 32'hF9F9F9F9);

        // Async reset mid-SHOW with a value pending: pending is discarded
        for (int k = 0; k < 6; k++) begin
            tick();
            check_frame_cycle("rst_pre", k, 32'hF9F9F9F9);
            if (k == 3) begin
                bcd_in     = 16'h9999;
                load_valid = 1'b1;
            end
            if (k == 4) begin
                check("rst_pre_ready", 32'(load_ready), 32'd0);
                load_valid = 1'b0;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_seg", 32'(segment), 32'hFF);
        check("async_rst_an", 32'(digit_an), 32'hF);
        check("async_rst_ready", 32'(load_ready), 32'd1);
        check("async_rst_fd", 32'(frame_done), 32'd0);
        tick();
        check("rst_hold_an", 32'(digit_an), 32'hF);
        rst_n = 1'b1;
        check_frame("post_rst", 32'hC0C0C0C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
